// File: rtl/banner_pkg.sv
// Shared types and defaults for the rotating seven-segment banner controller.
package banner_pkg;

  localparam int CHAR_W_DEF  = 5;
  localparam int MSG_MAX_DEF = 16;

  // Character code driven while a digit is dark
  localparam int BLANK_CODE = 0;

  typedef enum logic [1:0] {
    STOPPED   = 2'd0,
    SCROLLING = 2'd1,
    HOLD      = 2'd2
  } scan_state_t;

  function automatic logic [4:0] clamp_len(input logic [4:0] len, input int max_len);
    return (len > 5'(max_len)) ? 5'(max_len) : len;
  endfunction

endpackage

// File: rtl/banner_scan_ctrl_tick_prescaler.sv
// Free-running 0..DIV-1 prescaler; tick is high for the terminal-count cycle.
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = !clr && (cnt == W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/banner_scan_ctrl.sv
// Scan/rotation controller for the 8-digit banner: digit scan, message buffer, scroll FSM.
// Optional BANNER_HOLD_BLINK_EN flashes the whole display while pausing at offset 0.
//
// state     | meaning
// STOPPED   | run=0, step prescaler cleared, offset frozen
// SCROLLING | each step tick moves offset by one position per dir
// HOLD      | offset parked at 0 for HOLD_STEPS step ticks
module banner_scan_ctrl
  import banner_pkg::*;
#(
  parameter int REFRESH_DIV = 12500,
  parameter int STEP_DIV    = 25000000,
  parameter int HOLD_STEPS  = 4,
  parameter int MSG_MAX     = MSG_MAX_DEF,
  parameter int CHAR_W      = CHAR_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_MAX)-1:0] wr_addr,
  input  logic [CHAR_W-1:0]          wr_data,
  input  logic [4:0]                 msg_len,
  input  logic                       run,
  input  logic                       dir,
  output logic [3:0]                 refresh_counter,
  output logic [CHAR_W-1:0]          char_code,
  output logic                       blank,
  output logic [3:0]                 offset
);

  localparam int AW = $clog2(MSG_MAX);
  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  logic [CHAR_W-1:0] msg_buf [MSG_MAX];
  logic [4:0]        len;
  logic [4:0]        len_div;
  logic              slot_tick;
  logic              step_tick;
  logic              step_clr;

  scan_state_t       state, state_nxt;
  logic [HW-1:0]     hold_cnt, hold_nxt;
  logic [3:0]        off_nxt;
  logic [2:0]        idx_nxt;
  logic              stepped;
  logic [4:0]        pos_sum;
  logic [AW-1:0]     pos;
  logic [CHAR_W-1:0] char_nxt;
  logic              blank_nxt;

  assign len      = clamp_len(msg_len, MSG_MAX);
  assign len_div  = (len == 5'd0) ? 5'd1 : len;
  assign step_clr = !run || (state == STOPPED);

  tick_prescaler #(.DIV(REFRESH_DIV)) u_slot_pre (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .tick  (slot_tick)
  );

  tick_prescaler #(.DIV(STEP_DIV)) u_step_pre (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (step_clr),
    .tick  (step_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_MAX; i++) begin
        msg_buf[i] <= '0;
      end
    end else if (wr_en) begin
      msg_buf[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    idx_nxt   = slot_tick ? refresh_counter[2:0] - 3'd1 : refresh_counter[2:0];
    state_nxt = state;
    hold_nxt  = hold_cnt;
    off_nxt   = offset;
    stepped   = 1'b0;

    // A shrunk message must never leave offset pointing past its end; this beats a step
    if (len == 5'd0 || {1'b0, offset} >= len) begin
      off_nxt = 4'd0;
    end else if (state == SCROLLING && step_tick) begin
      stepped = 1'b1;
      if (dir) begin
        off_nxt = (offset == 4'd0) ? 4'(len - 5'd1) : offset - 4'd1;
      end else begin
        off_nxt = ({1'b0, offset} + 5'd1 == len) ? 4'd0 : offset + 4'd1;
      end
    end

    if (!run) begin
      state_nxt = STOPPED;
      hold_nxt  = '0;
    end else begin
      case (state)
        STOPPED: state_nxt = SCROLLING;
        SCROLLING: begin
          if (stepped && off_nxt == 4'd0 && HOLD_STEPS > 0) begin
            state_nxt = HOLD;
            hold_nxt  = '0;
          end
        end
        HOLD: begin
          if (step_tick) begin
            if (hold_cnt == HW'(HOLD_STEPS - 1)) begin
              state_nxt = SCROLLING;
              hold_nxt  = '0;
            end else begin
              hold_nxt = hold_cnt + 1'b1;
            end
          end
        end
        default: begin
          state_nxt = STOPPED;
          hold_nxt  = '0;
        end
      endcase
    end

    pos_sum  = {1'b0, off_nxt} + {2'b00, ~idx_nxt};
    pos      = AW'(pos_sum % len_div);
    char_nxt = (len == 5'd0) ? CHAR_W'(BLANK_CODE) : msg_buf[pos];
  end

`ifdef BANNER_HOLD_BLINK_EN
  logic blink, blink_nxt;

  always_comb begin
    blink_nxt = blink;
    if (state_nxt != HOLD) begin
      blink_nxt = 1'b0;
    end else if (state != HOLD) begin
      blink_nxt = 1'b1;
    end else if (step_tick) begin
      blink_nxt = ~blink;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink <= 1'b0;
    end else begin
      blink <= blink_nxt;
    end
  end

  assign blank_nxt = (len == 5'd0) || (state_nxt == HOLD && blink_nxt);
`else
  assign blank_nxt = (len == 5'd0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= STOPPED;
      hold_cnt        <= '0;
      offset          <= 4'd0;
      refresh_counter <= 4'd0;
      char_code       <= CHAR_W'(BLANK_CODE);
      blank           <= 1'b1;
    end else begin
      state           <= state_nxt;
      hold_cnt        <= hold_nxt;
      offset          <= off_nxt;
      refresh_counter <= {1'b0, idx_nxt};
      char_code       <= char_nxt;
      blank           <= blank_nxt;
    end
  end

endmodule
